na_write_wb: RTL and testbench

// - Egress path debug->NoC: accepts 16-bit DI payload flits from depacketizer, pairs them into 32-bit NoC flits,

---
 rtl/na_bridge_pkg.sv | 21 ++
 rtl/flit_buffer_16_to_32_bit.sv | 45 ++++
 rtl/na_write_wb.sv | 155 +++++++++++++++
 tb/tb_na_write_wb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/na_bridge_pkg.sv
// Shared types and constants for the DI-NA bridge write path.
package na_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DISCARD,
    WR_LEN,
    WR_DATA
  } state_t;

  // Endpoint register offsets inside one NA endpoint window
  localparam logic [31:0] LEN_OFS  = 32'h0;
  localparam logic [31:0] DATA_OFS = 32'h4;

  // DI header flit layout: {tdm, rsvd[6:0], ep[7:0]}
  localparam int HDR_TDM_BIT = 15;
  localparam int HDR_EP_LSB  = 0;
  localparam int HDR_EP_W    = 8;

endpackage

// File: rtl/flit_buffer_16_to_32_bit.sv
// Pairs 16-bit DI payload flits into 32-bit NoC words (high half first),
// zero-padding the low half when a packet ends on an odd flit.
module flit_buffer_16_to_32_bit #(
  parameter int MAX_NOC_PKT_LEN = 10,
  parameter int CNT_W           = $clog2(MAX_NOC_PKT_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             word_valid,
  output logic [31:0]      word,
  output logic             word_last,
  output logic [CNT_W-1:0] word_cnt
);

  logic        phase;
  logic [15:0] hi;

  // A word completes on the second half, or early on a lone final half
  assign word_valid = in_valid & (phase | in_last);
  assign word       = phase ? {hi, in_data} : {in_data, 16'h0};
  assign word_last  = in_valid & in_last;

  // Half-pair assembly state and count of words emitted so far (= next write index)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= 1'b0;
      hi       <= '0;
      word_cnt <= '0;
    end else if (clr) begin
      phase    <= 1'b0;
      hi       <= '0;
      word_cnt <= '0;
    end else if (in_valid) begin
      phase <= ~phase & ~in_last;
      if (!phase) hi <= in_data;
      // Saturate: the overflowing word is never stored, the packet is discarded
      if (word_valid && word_cnt != CNT_W'(MAX_NOC_PKT_LEN)) word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/na_write_wb.sv
// DI -> NoC egress: collects one DI packet into 32-bit words, then writes
// length and payload words into the selected NA endpoint over classic Wishbone.
import na_bridge_pkg::*;

module na_write_wb #(
  parameter int          MAX_NOC_PKT_LEN   = 10,
  parameter int          DI_FLIT_WIDTH     = 16,
  parameter int          NOC_FLIT_WIDTH    = 32,
  parameter int          NUM_BE_ENDPOINTS  = 1,
  parameter int          NUM_TDM_ENDPOINTS = 1,
  parameter logic [31:0] TDM_BASE          = 32'h0000,
  parameter logic [31:0] BE_BASE           = 32'h1000,
  parameter logic [31:0] EP_STRIDE         = 32'h100
) (
  input  logic                      clk,
  input  logic                      rst_debug_n,
  input  logic                      enable,
  input  logic [DI_FLIT_WIDTH-1:0]  in_flit_data,
  input  logic                      in_flit_valid,
  input  logic                      in_flit_last,
  output logic                      in_flit_ready,
  output logic [31:0]               wb_adr_o,
  output logic [NOC_FLIT_WIDTH-1:0] wb_dat_o,
  output logic [3:0]                wb_sel_o,
  output logic                      wb_we_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i,
  output logic                      err_drop,
  output logic                      busy
);

  localparam int CNT_W = $clog2(MAX_NOC_PKT_LEN + 1);

  state_t                    state, nxt;
  logic                      cyc, cyc_nxt, drop_nxt, rd_inc;
  logic                      tdm_q;
  logic [HDR_EP_W-1:0]       ep_q;
  logic [CNT_W-1:0]          rd_ptr;
  logic [NOC_FLIT_WIDTH-1:0] mem [MAX_NOC_PKT_LEN];

  logic             accept, hdr_ep_ok, ovf;
  logic             word_valid, word_last;
  logic [31:0]      word;
  logic [CNT_W-1:0] word_cnt;
  logic [31:0]      base;

  assign in_flit_ready = (state == IDLE && enable) || state == COLLECT || state == DISCARD;
  assign accept        = in_flit_valid & in_flit_ready;
  assign busy          = (state != IDLE);
  assign hdr_ep_ok     = in_flit_data[HDR_TDM_BIT]
                       ? int'(in_flit_data[HDR_EP_LSB +: HDR_EP_W]) < NUM_TDM_ENDPOINTS
                       : int'(in_flit_data[HDR_EP_LSB +: HDR_EP_W]) < NUM_BE_ENDPOINTS;

  flit_buffer_16_to_32_bit #(.MAX_NOC_PKT_LEN(MAX_NOC_PKT_LEN), .CNT_W(CNT_W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_debug_n),
    .clr       (state == IDLE),
    .in_valid  (accept && state == COLLECT),
    .in_data   (in_flit_data),
    .in_last   (in_flit_last),
    .word_valid(word_valid),
    .word      (word),
    .word_last (word_last),
    .word_cnt  (word_cnt)
  );

  // A completed word with the buffer already full means the packet is too long
  assign ovf = word_valid && word_cnt == CNT_W'(MAX_NOC_PKT_LEN);

  // Outputs are gated by cyc so they read zero while the bus is idle
  assign base     = tdm_q ? TDM_BASE : BE_BASE;
  assign wb_adr_o = cyc ? base + 32'(ep_q) * EP_STRIDE + ((state == WR_DATA) ? DATA_OFS : LEN_OFS) : '0;
  assign wb_dat_o = !cyc ? '0 : (state == WR_LEN) ? NOC_FLIT_WIDTH'(word_cnt) : mem[rd_ptr];
  assign wb_sel_o = 4'hF;
  assign wb_we_o  = cyc;
  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;

  // Next-state, strobe and drop decisions
  always_comb begin
    nxt      = state;
    cyc_nxt  = cyc;
    drop_nxt = 1'b0;
    rd_inc   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (in_flit_last)    drop_nxt = 1'b1;
        else if (!hdr_ep_ok) nxt = DISCARD;
        else                 nxt = COLLECT;
      end
      COLLECT: if (accept) begin
        if (ovf) begin
          if (word_last) begin nxt = IDLE; drop_nxt = 1'b1; end
          else nxt = DISCARD;
        end else if (word_last) begin
          nxt     = WR_LEN;
          cyc_nxt = 1'b1;
        end
      end
      DISCARD: if (accept && in_flit_last) begin
        nxt      = IDLE;
        drop_nxt = 1'b1;
      end
      WR_LEN: if (cyc && wb_err_i) begin
        nxt = IDLE; cyc_nxt = 1'b0; drop_nxt = 1'b1;
      end else if (cyc && wb_ack_i) begin
        nxt = WR_DATA; cyc_nxt = 1'b0;
      end
      WR_DATA: if (!cyc) begin
        cyc_nxt = 1'b1;
      end else if (wb_err_i) begin
        nxt = IDLE; cyc_nxt = 1'b0; drop_nxt = 1'b1;
      end else if (wb_ack_i) begin
        cyc_nxt = 1'b0;
        rd_inc  = 1'b1;
        if (rd_ptr == word_cnt - 1'b1) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // State, bus strobe, drop pulse, header capture and read pointer
  always_ff @(posedge clk or negedge rst_debug_n) begin
    if (!rst_debug_n) begin
      state    <= IDLE;
      cyc      <= 1'b0;
      err_drop <= 1'b0;
      tdm_q    <= 1'b0;
      ep_q     <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= nxt;
      cyc      <= cyc_nxt;
      err_drop <= drop_nxt;
      if (state == IDLE && accept) begin
        tdm_q <= in_flit_data[HDR_TDM_BIT];
        ep_q  <= in_flit_data[HDR_EP_LSB +: HDR_EP_W];
      end
      if (state == IDLE) rd_ptr <= '0;
      else if (rd_inc)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Packet RAM: words stored in arrival order
  always_ff @(posedge clk or negedge rst_debug_n) begin
    if (!rst_debug_n) begin
      for (int i = 0; i < MAX_NOC_PKT_LEN; i++) mem[i] <= '0;
    end else if (state == COLLECT && word_valid && !ovf) begin
      mem[word_cnt] <= word;
    end
  end

endmodule

// File: tb/tb_na_write_wb.sv
// Randomized + directed bench for na_write_wb against a packet-level model.
module tb_na_write_wb;

  localparam int MAX = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] in_flit_data = '0;
  logic        in_flit_valid = 1'b0;
  logic        in_flit_last = 1'b0;
  logic        in_flit_ready;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic        err_drop, busy;

  always #5 clk = ~clk;

  na_write_wb #(.MAX_NOC_PKT_LEN(MAX)) dut (
    .clk(clk), .rst_debug_n(rst_n), .enable(enable),
    .in_flit_data(in_flit_data), .in_flit_valid(in_flit_valid),
    .in_flit_last(in_flit_last), .in_flit_ready(in_flit_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .err_drop(err_drop), .busy(busy)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [63:0] got_q[$], exp_q[$];
  int drops = 0, exp_drops = 0;
  int stall_max = 2, stall_fix = -1, err_at = -1, acc_idx = 0, scnt = 0;
  bit drop_en = 1'b0;

  // Wishbone slave: acks (or errors) after a chosen number of stall cycles
  initial begin
    forever begin
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (!rst_n) scnt = 0;
      else if (wb_cyc_o) begin
        if (scnt == 0) scnt = ((stall_fix >= 0) ? stall_fix : $urandom_range(stall_max, 0)) + 1;
        scnt--;
        if (scnt == 0) begin
          if (acc_idx == err_at) wb_err_i = 1'b1;
          else wb_ack_i = 1'b1;
          acc_idx++;
        end
      end
    end
  end

  // Bus monitor: protocol checks and capture of completed writes
  logic        hold_q = 1'b0;
  logic [31:0] hadr = '0, hdat = '0;
  always @(posedge clk) begin
    if (rst_n && wb_cyc_o) begin
      chk("wb_ctl", {26'h0, wb_stb_o, wb_we_o, wb_sel_o}, 32'h3F);
      chk("rdy_in_wb", in_flit_ready, 1'b0);
      if (hold_q) begin
        chk("adr_hold", wb_adr_o, hadr);
        chk("dat_hold", wb_dat_o, hdat);
      end
      if (wb_ack_i && !wb_err_i) got_q.push_back({wb_adr_o, wb_dat_o});
    end
    hold_q <= rst_n && wb_cyc_o && !wb_ack_i && !wb_err_i;
    hadr   <= wb_adr_o;
    hdat   <= wb_dat_o;
    if (err_drop) drops <= drops + 1;
  end

  // Reference model: expected write list or drop for one packet
  task automatic model(input logic [15:0] hdr, input logic [15:0] pl[$], input int err_k);
    int n = pl.size();
    int words = (n + 1) / 2;
    int ep = int'(hdr[7:0]);
    logic [31:0] base, d;
    if (n == 0 || ep >= 1 || words > MAX) begin exp_drops++; return; end
    base = (hdr[15] ? 32'h0 : 32'h1000) + ep * 32'h100;
    for (int k = 0; k <= words; k++) begin
      if (k == err_k) begin exp_drops++; return; end
      if (k == 0) d = words;
      else d = {pl[2*k-2], (2*k-1 < n) ? pl[2*k-1] : 16'h0};
      exp_q.push_back({base + ((k == 0) ? 32'h0 : 32'h4), d});
    end
  endtask

  task automatic put(input logic [15:0] d, input logic l);
    int t = 0;
    @(negedge clk);
    in_flit_data = d; in_flit_last = l; in_flit_valid = 1'b1;
    while (!in_flit_ready && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) chk("rdy_timeout", t, 0);
    @(posedge clk); #1;
    in_flit_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] hdr, input logic [15:0] pl[$]);
    put(hdr, pl.size() == 0);
    if (drop_en) enable = 1'b0;
    foreach (pl[i]) begin
      if ($urandom_range(3, 0) == 0) repeat ($urandom_range(2, 1)) @(negedge clk);
      put(pl[i], i == pl.size() - 1);
    end
  endtask

  task automatic drain();
    int t = 0;
    logic [63:0] g, e;
    repeat (2) @(negedge clk);
    while ((busy || wb_cyc_o) && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) chk("drain_timeout", t, 0);
    repeat (2) @(negedge clk);
    chk("drops", drops, exp_drops);
    chk("nwrites", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      chk("wr_adr", g[63:32], e[63:32]);
      chk("wr_dat", g[31:0], e[31:0]);
    end
    got_q.delete(); exp_q.delete();
  endtask

  function automatic void mkpl(output logic [15:0] pl[$], input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(16'($urandom));
  endfunction

  initial begin
    logic [15:0] pl[$], pb[$];
    logic [15:0] hdr;
    int n, t;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_sel", wb_sel_o, 4'hF);
    chk("rst_busy", busy, 0);
    chk("rst_drop", err_drop, 0);
    chk("rst_rdy", in_flit_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rdy_dis", in_flit_ready, 0);
    enable = 1'b1;
    @(negedge clk);
    chk("idle_rdy_en", in_flit_ready, 1);

    // TDM ep0, even payload; strobe one cycle after last flit
    pl = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    model(16'h8000, pl, -1);
    send(16'h8000, pl);
    chk("first_stb_lat", wb_cyc_o, 1);
    drain();

    // BE ep0, odd payload -> zero padded low half
    pl = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    model(16'h0000, pl, -1);
    send(16'h0000, pl);
    drain();

    // 21 flits overflow, 20 flits exactly fills buffer
    mkpl(pl, 21); model(16'h8000, pl, -1); send(16'h8000, pl); drain();
    mkpl(pl, 20); model(16'h8000, pl, -1); send(16'h8000, pl); drain();

    // out-of-range endpoint, header-only packet
    mkpl(pl, 4); model(16'h8005, pl, -1); send(16'h8005, pl); drain();
    pl.delete(); model(16'h8000, pl, -1); send(16'h8000, pl); drain();

    // bus error on the second access
    err_at = 1; acc_idx = 0;
    mkpl(pl, 6); model(16'h0000, pl, 1); send(16'h0000, pl); drain();
    err_at = -1;

    // 7-cycle ack stall while the next packet is already offered
    stall_fix = 7;
    mkpl(pl, 5); mkpl(pb, 3);
    model(16'h8000, pl, -1); model(16'h0000, pb, -1);
    send(16'h8000, pl); send(16'h0000, pb);
    drain();
    stall_fix = -1;

    // enable dropped mid-packet: packet finishes, then no new packets
    drop_en = 1'b1;
    mkpl(pl, 4); model(16'h8000, pl, -1); send(16'h8000, pl); drain();
    drop_en = 1'b0;
    @(negedge clk);
    in_flit_data = 16'h8000; in_flit_valid = 1'b1; in_flit_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("en_off_rdy", in_flit_ready, 0);
    chk("en_off_busy", busy, 0);
    in_flit_valid = 1'b0;
    enable = 1'b1;

    // asynchronous reset during the data phase
    stall_fix = 3;
    mkpl(pl, 8); send(16'h8000, pl);
    t = 0;
    while ((got_q.size() < 2 || !wb_cyc_o) && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) chk("rst_wait_timeout", t, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cyc", wb_cyc_o, 0);
    chk("async_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete(); exp_q.delete();
    stall_fix = -1;
    mkpl(pl, 7); model(16'h8000, pl, -1); send(16'h8000, pl); drain();

    // randomized packets
    for (int p = 0; p < 30; p++) begin
      n = $urandom_range(22, 0);
      hdr = {1'($urandom), 7'($urandom), ($urandom_range(4, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h0};
      mkpl(pl, n);
      stall_max = $urandom_range(3, 0);
      acc_idx = 0;
      err_at = ($urandom_range(4, 0) == 0) ? $urandom_range(6, 0) : -1;
      model(hdr, pl, err_at);
      send(hdr, pl);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
